// File: rtl/wb_bus_arbiter.sv
// Two-master (instruction M0, data M1) to one-slave Wishbone B4 round-robin arbiter.
// Optional stall watchdog is compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_adr_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   output logic [1:0]  grant_o
);

   typedef enum logic [1:0] {StIdle, StOwnM0, StOwnM1} state_t;

   state_t      r_state;
   logic        r_last;   // 0: M0 was granted last, 1: M1
   logic [1:0]  r_grant;
   logic        w_req0, w_req1, w_own0, w_own1;
   logic        w_cyc, w_stb, w_timeout;

   if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 2..255");
   end

   assign w_req0 = m0_cyc_i & m0_stb_i;
   assign w_req1 = m1_cyc_i & m1_stb_i;
   assign w_own0 = (r_state == StOwnM0);
   assign w_own1 = (r_state == StOwnM1);

   always_comb begin
      w_cyc   = 1'b0;
      w_stb   = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      if (w_own0) begin
         w_cyc   = m0_cyc_i;
         w_stb   = m0_stb_i;
         s_adr_o = m0_adr_i;
         s_sel_o = 4'b1111;
      end else if (w_own1) begin
         w_cyc   = m1_cyc_i;
         w_stb   = m1_stb_i;
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_we_o  = m1_we_i;
         s_sel_o = m1_sel_i;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [7:0] StallMax = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_stall;

   // Fires on the TIMEOUT_CYCLES-th consecutive unanswered strobe cycle.
   assign w_timeout = (w_own0 | w_own1) & w_cyc & w_stb & ~s_ack_i & ~s_err_i &
                      (r_stall == StallMax);

   always_ff @(posedge clk) begin
      if (rst || r_state == StIdle || s_ack_i || s_err_i || w_timeout) begin
         r_stall <= '0;
      end else if (w_cyc && w_stb) begin
         r_stall <= r_stall + 8'd1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   assign s_cyc_o  = w_cyc & ~w_timeout;
   assign s_stb_o  = w_stb & ~w_timeout;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = w_own0 & s_ack_i & ~s_err_i;
   assign m1_ack_o = w_own1 & s_ack_i & ~s_err_i;
   assign m0_err_o = w_own0 & (s_err_i | w_timeout);
   assign m1_err_o = w_own1 & (s_err_i | w_timeout);
   assign grant_o  = r_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_last  <= 1'b0;
         r_grant <= 2'b00;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_req1 && (!w_req0 || !r_last)) begin
                  r_state <= StOwnM1;
                  r_last  <= 1'b1;
                  r_grant <= 2'b10;
               end else if (w_req0) begin
                  r_state <= StOwnM0;
                  r_last  <= 1'b0;
                  r_grant <= 2'b01;
               end
            end
            StOwnM0: begin
               if (!m0_cyc_i || w_timeout) begin
                  r_state <= StIdle;
                  r_grant <= 2'b00;
               end
            end
            StOwnM1: begin
               if (!m1_cyc_i || w_timeout) begin
                  r_state <= StIdle;
                  r_grant <= 2'b00;
               end
            end
            default: begin
               r_state <= StIdle;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed self-checking bench for wb_bus_arbiter (TIMEOUT_CYCLES = 8).
module tb_wb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_adr_i;
   logic        m0_cyc_i, m0_stb_i;
   logic [31:0] m0_dat_o;
   logic        m0_ack_o, m0_err_o;
   logic [31:0] m1_adr_i, m1_dat_i;
   logic        m1_we_i;
   logic [3:0]  m1_sel_i;
   logic        m1_cyc_i, m1_stb_i;
   logic [31:0] m1_dat_o;
   logic        m1_ack_o, m1_err_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic        s_we_o;
   logic [3:0]  s_sel_o;
   logic        s_cyc_o, s_stb_o;
   logic [31:0] s_dat_i;
   logic        s_ack_i, s_err_i;
   logic [1:0]  grant_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wb_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .m0_adr_i (m0_adr_i),
      .m0_cyc_i (m0_cyc_i),
      .m0_stb_i (m0_stb_i),
      .m0_dat_o (m0_dat_o),
      .m0_ack_o (m0_ack_o),
      .m0_err_o (m0_err_o),
      .m1_adr_i (m1_adr_i),
      .m1_dat_i (m1_dat_i),
      .m1_we_i  (m1_we_i),
      .m1_sel_i (m1_sel_i),
      .m1_cyc_i (m1_cyc_i),
      .m1_stb_i (m1_stb_i),
      .m1_dat_o (m1_dat_o),
      .m1_ack_o (m1_ack_o),
      .m1_err_o (m1_err_o),
      .s_adr_o  (s_adr_o),
      .s_dat_o  (s_dat_o),
      .s_we_o   (s_we_o),
      .s_sel_o  (s_sel_o),
      .s_cyc_o  (s_cyc_o),
      .s_stb_o  (s_stb_o),
      .s_dat_i  (s_dat_i),
      .s_ack_i  (s_ack_i),
      .s_err_i  (s_err_i),
      .grant_o  (grant_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL bench_timeout: got hang expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst = 1'b1;
      m0_adr_i = '0; m0_cyc_i = 0; m0_stb_i = 0;
      m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = '0; m1_cyc_i = 0; m1_stb_i = 0;
      s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
      do_reset();
      settle();
      check_eq("rst_grant", 32'(grant_o), 32'h0);
      check_eq("rst_cyc", 32'(s_cyc_o), 32'h0);
      check_eq("rst_stb", 32'(s_stb_o), 32'h0);
      check_eq("rst_adr", s_adr_o, 32'h0);

      // M0 read of 0x100, slave acks 2 cycles after strobe
      m0_adr_i = 32'h100; m0_cyc_i = 1; m0_stb_i = 1;
      settle();
      check_eq("m0_stb_not_yet", 32'(s_stb_o), 32'h0);
      step();
      check_eq("m0_grant", 32'(grant_o), 32'h1);
      check_eq("m0_stb", 32'(s_stb_o), 32'h1);
      check_eq("m0_adr", s_adr_o, 32'h100);
      check_eq("m0_sel", 32'(s_sel_o), 32'hF);
      check_eq("m0_we", 32'(s_we_o), 32'h0);
      step();
      check_eq("m0_ack_wait", 32'(m0_ack_o), 32'h0);
      step();
      s_ack_i = 1; s_dat_i = 32'hCAFE0001;
      settle();
      check_eq("m0_ack", 32'(m0_ack_o), 32'h1);
      check_eq("m0_dat", m0_dat_o, 32'hCAFE0001);
      check_eq("m1_ack_quiet", 32'(m1_ack_o), 32'h0);
      step();
      s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      settle();
      check_eq("m0_drop_cyc_comb", 32'(s_cyc_o), 32'h0);
      step();
      check_eq("m0_release", 32'(grant_o), 32'h0);

      // Simultaneous requests after reset: M1 first, with a write and a 3-strobe burst
      do_reset();
      m0_adr_i = 32'h100; m0_cyc_i = 1; m0_stb_i = 1;
      m1_adr_i = 32'h2004; m1_dat_i = 32'hDEADBEEF; m1_we_i = 1; m1_sel_i = 4'b0011;
      m1_cyc_i = 1; m1_stb_i = 1;
      step();
      check_eq("tie_grant_m1", 32'(grant_o), 32'h2);
      check_eq("wr_adr", s_adr_o, 32'h2004);
      check_eq("wr_dat", s_dat_o, 32'hDEADBEEF);
      check_eq("wr_we", 32'(s_we_o), 32'h1);
      check_eq("wr_sel", 32'(s_sel_o), 32'h3);
      s_ack_i = 1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_eq($sformatf("burst_ack%0d", i), 32'(m1_ack_o), 32'h1);
         check_eq($sformatf("burst_grant%0d", i), 32'(grant_o), 32'h2);
         check_eq($sformatf("burst_m0_ack%0d", i), 32'(m0_ack_o), 32'h0);
         step();
      end
      s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
      step();
      check_eq("gap_idle", 32'(grant_o), 32'h0);
      step();
      check_eq("then_m0", 32'(grant_o), 32'h1);
      check_eq("then_m0_adr", s_adr_o, 32'h100);

      // err beats ack
      s_ack_i = 1; s_err_i = 1;
      settle();
      check_eq("err_wins_err", 32'(m0_err_o), 32'h1);
      check_eq("err_wins_ack", 32'(m0_ack_o), 32'h0);
      check_eq("err_m1_quiet", 32'(m1_err_o), 32'h0);
      s_ack_i = 0; s_err_i = 0;

      // Reset while M0 waits on ack; late ack dropped
      rst = 1;
      step();
      rst = 0; s_ack_i = 1;
      settle();
      check_eq("midrst_grant", 32'(grant_o), 32'h0);
      check_eq("midrst_cyc", 32'(s_cyc_o), 32'h0);
      check_eq("midrst_ack", 32'(m0_ack_o), 32'h0);
      s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      step();
      step();

      // Stalled M1 read: slave never answers
      m1_adr_i = 32'h3000; m1_cyc_i = 1; m1_stb_i = 1;
      step();
      check_eq("stall_grant", 32'(grant_o), 32'h2);
`ifdef WB_ARB_TIMEOUT_EN
      for (int k = 1; k <= 8; k++) begin
         settle();
         check_eq($sformatf("to_err_c%0d", k), 32'(m1_err_o), (k == 8) ? 32'h1 : 32'h0);
         if (k == 8) check_eq("to_stb_forced", 32'(s_stb_o), 32'h0);
         step();
      end
      check_eq("to_idle", 32'(grant_o), 32'h0);
      check_eq("to_err_once", 32'(m1_err_o), 32'h0);
      m1_cyc_i = 0; m1_stb_i = 0;
`else
      for (int k = 1; k <= 100; k++) begin
         settle();
         check_eq($sformatf("noto_err_c%0d", k), 32'(m1_err_o), 32'h0);
         step();
      end
      check_eq("noto_grant", 32'(grant_o), 32'h2);
      m1_cyc_i = 0; m1_stb_i = 0;
      step();
      check_eq("noto_release", 32'(grant_o), 32'h0);
`endif
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
